instruction_fetch_unit: RTL and testbench

Byte-serial instruction fetch stage for the 6502 core. It sits between the program ROM and the control unit. It walks the program counter, reads opcode and operand bytes over the 16-bit address / 8-bit data bus, and sizes each instruction from its opcode. Each complete instruction is handed to the control unit through a valid/ready handshake, and the control unit can redirect fetch for jumps and branches.

---
 rtl/cpu6502_pkg.sv | 58 +++++
 rtl/opcode_length_decoder.sv | 13 +
 rtl/instruction_fetch_unit.sv | 139 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu6502_pkg.sv
// Shared definitions for the 6502 core front end.
//   fetch_state_e    : instruction fetch FSM state encoding
//   DEFAULT_RESET_PC : default program counter after reset
//   opcode_length()  : instruction length in bytes (1..3) from the opcode
package cpu6502_pkg;

    typedef enum logic [1:0] {
        FETCH_OP = 2'd0,
        FETCH_LO = 2'd1,
        FETCH_HI = 2'd2,
        HOLD     = 2'd3
    } fetch_state_e;

    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

    // Length follows the 6502 aaa-bbb-cc opcode grid: cc selects the group,
    // bbb the addressing mode. Group cc=00 has irregular column bbb=000
    // (BRK/RTI/RTS are single byte, JSR is absolute).
    function automatic logic [1:0] opcode_length(input logic [7:0] opcode);
        logic [1:0] cc;
        logic [2:0] bbb;
        logic [1:0] len;
        cc  = opcode[1:0];
        bbb = opcode[4:2];
        len = 2'd1;
        case (cc)
            2'b01: begin
                if (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111)
                    len = 2'd3;
                else
                    len = 2'd2;
            end
            2'b10: begin
                case (bbb)
                    3'b000, 3'b001, 3'b101: len = 2'd2;
                    3'b011, 3'b111:         len = 2'd3;
                    default:                len = 2'd1;
                endcase
            end
            2'b00: begin
                if (opcode == 8'h20)
                    len = 2'd3;
                else if (opcode == 8'h00 || opcode == 8'h40 || opcode == 8'h60)
                    len = 2'd1;
                else begin
                    case (bbb)
                        3'b000, 3'b001, 3'b100, 3'b101: len = 2'd2;
                        3'b011, 3'b111:                 len = 2'd3;
                        default:                        len = 2'd1;
                    endcase
                end
            end
            default: len = 2'd1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/opcode_length_decoder.sv
// Combinational opcode length decoder.
//   opcode : instruction opcode byte
//   len    : instruction length in bytes (1, 2 or 3)
module opcode_length_decoder
    import cpu6502_pkg::*;
(
    input  logic [7:0] opcode,
    output logic [1:0] len
);

    assign len = opcode_length(opcode);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Byte-serial instruction fetch stage between program ROM and control unit.
// Walks the PC, reads opcode/operand bytes, and presents each complete
// instruction through a valid/ready handshake. Redirect reloads the PC.
//   clk_in, reset          : clock, async active-high reset
//   ce                     : clock enable; all registers hold when low
//   mem_addr/mem_rd        : ROM address and read strobe
//   mem_data               : ROM data, combinational from mem_addr
//   redirect_valid/_pc     : load new fetch PC, dropping current work
//   ins_valid/ins_ready    : bundle handshake
//   ins_opcode/_operand/_len/_pc : instruction bundle
//
// state    | meaning
// FETCH_OP | read opcode byte at pc
// FETCH_LO | read operand low byte
// FETCH_HI | read operand high byte
// HOLD     | bundle valid, waiting for acceptance
module instruction_fetch_unit
    import cpu6502_pkg::*;
#(
    parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        ce,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [7:0]  ins_opcode,
    output logic [15:0] ins_operand,
    output logic [1:0]  ins_len,
    output logic [15:0] ins_pc
);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic         ins_valid_q, ins_valid_d;
    logic [7:0]   ins_opcode_q, ins_opcode_d;
    logic [15:0]  ins_operand_q, ins_operand_d;
    logic [1:0]   ins_len_q, ins_len_d;
    logic [15:0]  ins_pc_q, ins_pc_d;
    logic [1:0]   dec_len;

    opcode_length_decoder u_len_dec (
        .opcode (mem_data),
        .len    (dec_len)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ins_valid_d   = ins_valid_q;
        ins_opcode_d  = ins_opcode_q;
        ins_operand_d = ins_operand_q;
        ins_len_d     = ins_len_q;
        ins_pc_d      = ins_pc_q;
        if (ce) begin
            if (redirect_valid) begin
                // Overrides any handshake on the same edge; bundle is dropped.
                pc_d        = redirect_pc;
                state_d     = FETCH_OP;
                ins_valid_d = 1'b0;
            end else begin
                case (state_q)
                    FETCH_OP: begin
                        ins_opcode_d  = mem_data;
                        ins_pc_d      = pc_q;
                        ins_operand_d = 16'h0000;
                        ins_len_d     = dec_len;
                        pc_d          = pc_q + 16'd1;
                        if (dec_len == 2'd1) begin
                            state_d     = HOLD;
                            ins_valid_d = 1'b1;
                        end else begin
                            state_d = FETCH_LO;
                        end
                    end
                    FETCH_LO: begin
                        ins_operand_d[7:0] = mem_data;
                        pc_d               = pc_q + 16'd1;
                        if (ins_len_q == 2'd2) begin
                            state_d     = HOLD;
                            ins_valid_d = 1'b1;
                        end else begin
                            state_d = FETCH_HI;
                        end
                    end
                    FETCH_HI: begin
                        ins_operand_d[15:8] = mem_data;
                        pc_d                = pc_q + 16'd1;
                        state_d             = HOLD;
                        ins_valid_d         = 1'b1;
                    end
                    HOLD: begin
                        if (ins_valid_q && ins_ready) begin
                            state_d     = FETCH_OP;
                            ins_valid_d = 1'b0;
                        end
                    end
                    default: state_d = FETCH_OP;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q       <= FETCH_OP;
            pc_q          <= RESET_PC;
            ins_valid_q   <= 1'b0;
            ins_opcode_q  <= 8'h00;
            ins_operand_q <= 16'h0000;
            ins_len_q     <= 2'd1;
            ins_pc_q      <= RESET_PC;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ins_valid_q   <= ins_valid_d;
            ins_opcode_q  <= ins_opcode_d;
            ins_operand_q <= ins_operand_d;
            ins_len_q     <= ins_len_d;
            ins_pc_q      <= ins_pc_d;
        end
    end

    // Strobe is combinational on ce/reset so a stalled or resetting stage
    // never issues a ROM read.
    assign mem_rd      = ce && !reset && (state_q != HOLD);
    assign mem_addr    = pc_q;
    assign ins_valid   = ins_valid_q;
    assign ins_opcode  = ins_opcode_q;
    assign ins_operand = ins_operand_q;
    assign ins_len     = ins_len_q;
    assign ins_pc      = ins_pc_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        ce;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        ins_ready;

    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data;
    logic        ins_valid;
    logic [7:0]  ins_opcode;
    logic [15:0] ins_operand;
    logic [1:0]  ins_len;
    logic [15:0] ins_pc;

    logic [15:0] mem_addr_b;
    logic        mem_rd_b;
    logic [7:0]  mem_data_b;
    logic        ins_valid_b;
    logic [7:0]  ins_opcode_b;
    logic [15:0] ins_operand_b;
    logic [1:0]  ins_len_b;
    logic [15:0] ins_pc_b;
    logic        redirect_valid_b = 1'b0;
    logic [15:0] redirect_pc_b = 16'h0000;
    logic        ins_ready_b = 1'b0;

    logic [7:0]  dec_op;
    logic [1:0]  dec_len;

    logic [7:0]  rom [0:65535];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_in = ~clk_in;

    assign mem_data = rom[mem_addr];
    assign mem_data_b = (mem_addr_b == 16'hFFFE) ? 8'hAD :
                        (mem_addr_b == 16'hFFFF) ? 8'h00 :
                        (mem_addr_b == 16'h0000) ? 8'h80 : 8'hEA;

    instruction_fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk_in         (clk_in),
        .reset          (reset),
        .ce             (ce),
        .mem_addr       (mem_addr),
        .mem_rd         (mem_rd),
        .mem_data       (mem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ins_valid      (ins_valid),
        .ins_ready      (ins_ready),
        .ins_opcode     (ins_opcode),
        .ins_operand    (ins_operand),
        .ins_len        (ins_len),
        .ins_pc         (ins_pc)
    );

    instruction_fetch_unit #(.RESET_PC(16'hFFFE)) dut_wrap (
        .clk_in         (clk_in),
        .reset          (reset),
        .ce             (ce),
        .mem_addr       (mem_addr_b),
        .mem_rd         (mem_rd_b),
        .mem_data       (mem_data_b),
        .redirect_valid (redirect_valid_b),
        .redirect_pc    (redirect_pc_b),
        .ins_valid      (ins_valid_b),
        .ins_ready      (ins_ready_b),
        .ins_opcode     (ins_opcode_b),
        .ins_operand    (ins_operand_b),
        .ins_len        (ins_len_b),
        .ins_pc         (ins_pc_b)
    );

    opcode_length_decoder u_dec (
        .opcode (dec_op),
        .len    (dec_len)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    endtask

    task automatic check_bundle(input string tag, input logic [7:0] op, input logic [15:0] opnd,
                                input logic [1:0] len, input logic [15:0] pc);
        check_val({tag, ".valid"},   {31'd0, ins_valid}, 32'd1);
        check_val({tag, ".opcode"},  {24'd0, ins_opcode}, {24'd0, op});
        check_val({tag, ".operand"}, {16'd0, ins_operand}, {16'd0, opnd});
        check_val({tag, ".len"},     {30'd0, ins_len}, {30'd0, len});
        check_val({tag, ".pc"},      {16'd0, ins_pc}, {16'd0, pc});
    endtask

    task automatic tick();
        @(posedge clk_in);
        #2;
    endtask

    // Reference lengths by low nibble; rows differ by the high nibble's LSB.
    // Entry 0 of the even row depends on the full opcode and is handled apart.
    int even_row [16] = '{0, 2, 2, 1, 2, 2, 2, 1, 1, 2, 1, 1, 3, 3, 3, 1};
    int odd_row  [16] = '{2, 2, 1, 1, 2, 2, 2, 1, 1, 3, 1, 1, 3, 3, 3, 1};

    function automatic int ref_len(input int op);
        int hi, lo;
        hi = op / 16;
        lo = op % 16;
        if (hi % 2 == 1) return odd_row[lo];
        if (lo != 0)     return even_row[lo];
        if (op == 8'h20) return 3;
        if (op == 8'h00 || op == 8'h40 || op == 8'h60) return 1;
        return 2;
    endfunction

    initial begin
        for (int i = 0; i < 65536; i++) rom[i] = 8'hEA;
        rom[16'h0000] = 8'hA0; rom[16'h0001] = 8'hFF;
        rom[16'h0002] = 8'h4C; rom[16'h0003] = 8'h34; rom[16'h0004] = 8'h12;
        rom[16'h0005] = 8'hEA; rom[16'h0006] = 8'h0A;
        rom[16'h0007] = 8'h20; rom[16'h0008] = 8'h11; rom[16'h0009] = 8'h22;
        rom[16'h0100] = 8'hA9; rom[16'h0101] = 8'h55;

        reset = 1'b1; ce = 1'b1; ins_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 16'h0000;
        dec_op = 8'h00;
        repeat (2) tick();

        check_val("rst.valid",   {31'd0, ins_valid}, 32'd0);
        check_val("rst.mem_rd",  {31'd0, mem_rd}, 32'd0);
        check_val("rst.opcode",  {24'd0, ins_opcode}, 32'h00);
        check_val("rst.operand", {16'd0, ins_operand}, 32'h0000);
        check_val("rst.len",     {30'd0, ins_len}, 32'd1);
        check_val("rst.pc",      {16'd0, ins_pc}, 32'h0000);
        check_val("rst.addr",    {16'd0, mem_addr}, 32'h0000);
        check_val("rst_b.pc",    {16'd0, ins_pc_b}, 32'hFFFE);
        check_val("rst_b.addr",  {16'd0, mem_addr_b}, 32'hFFFE);

        reset = 1'b0;
        #1;
        check_val("op0.mem_rd", {31'd0, mem_rd}, 32'd1);
        check_val("op0.addr",   {16'd0, mem_addr}, 32'h0000);
        tick();
        check_val("lo0.valid", {31'd0, ins_valid}, 32'd0);
        check_val("lo0.addr",  {16'd0, mem_addr}, 32'h0001);
        tick();
        check_bundle("ldy", 8'hA0, 16'h00FF, 2'd2, 16'h0000);
        check_val("ldy.mem_rd", {31'd0, mem_rd}, 32'd0);
        check_val("ldy.addr",   {16'd0, mem_addr}, 32'h0002);
        tick();
        check_val("acc0.valid",  {31'd0, ins_valid}, 32'd0);
        check_val("acc0.addr",   {16'd0, mem_addr}, 32'h0002);
        check_val("acc0.mem_rd", {31'd0, mem_rd}, 32'd1);
        check_val("wrap.valid",   {31'd0, ins_valid_b}, 32'd1);
        check_val("wrap.opcode",  {24'd0, ins_opcode_b}, 32'hAD);
        check_val("wrap.operand", {16'd0, ins_operand_b}, 32'h8000);
        check_val("wrap.len",     {30'd0, ins_len_b}, 32'd3);
        check_val("wrap.pc",      {16'd0, ins_pc_b}, 32'hFFFE);
        check_val("wrap.addr",    {16'd0, mem_addr_b}, 32'h0001);

        ins_ready = 1'b0;
        repeat (3) tick();
        check_bundle("jmp", 8'h4C, 16'h1234, 2'd3, 16'h0002);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_bundle("jmp_hold", 8'h4C, 16'h1234, 2'd3, 16'h0002);
            check_val("jmp_hold.mem_rd", {31'd0, mem_rd}, 32'd0);
            check_val("jmp_hold.addr",   {16'd0, mem_addr}, 32'h0005);
        end
        ins_ready = 1'b1;
        tick();
        check_val("acc1.valid",  {31'd0, ins_valid}, 32'd0);
        check_val("acc1.addr",   {16'd0, mem_addr}, 32'h0005);
        check_val("acc1.mem_rd", {31'd0, mem_rd}, 32'd1);
        tick();
        check_bundle("nop", 8'hEA, 16'h0000, 2'd1, 16'h0005);
        tick();
        check_val("acc2.addr", {16'd0, mem_addr}, 32'h0006);
        tick();
        check_bundle("asl", 8'h0A, 16'h0000, 2'd1, 16'h0006);
        tick();
        check_val("jsr.op_addr", {16'd0, mem_addr}, 32'h0007);
        tick();
        check_val("jsr.lo_addr", {16'd0, mem_addr}, 32'h0008);
        check_val("jsr.lo_valid", {31'd0, ins_valid}, 32'd0);

        redirect_valid = 1'b1; redirect_pc = 16'h0100;
        tick();
        redirect_valid = 1'b0;
        check_val("redir.valid",  {31'd0, ins_valid}, 32'd0);
        check_val("redir.addr",   {16'd0, mem_addr}, 32'h0100);
        check_val("redir.mem_rd", {31'd0, mem_rd}, 32'd1);

        ce = 1'b0;
        #1;
        check_val("ce0.mem_rd", {31'd0, mem_rd}, 32'd0);
        tick();
        check_val("ce0.addr", {16'd0, mem_addr}, 32'h0100);
        ce = 1'b1;
        tick();
        check_val("ce1.addr", {16'd0, mem_addr}, 32'h0101);
        ce = 1'b0;
        tick();
        check_val("ce2.addr",  {16'd0, mem_addr}, 32'h0101);
        check_val("ce2.valid", {31'd0, ins_valid}, 32'd0);
        ce = 1'b1;
        tick();
        check_bundle("lda", 8'hA9, 16'h0055, 2'd2, 16'h0100);

        ins_ready = 1'b0;
        tick();
        check_val("hold.valid", {31'd0, ins_valid}, 32'd1);
        reset = 1'b1;
        #1;
        check_val("rst2.valid",  {31'd0, ins_valid}, 32'd0);
        check_val("rst2.mem_rd", {31'd0, mem_rd}, 32'd0);
        check_val("rst2.addr",   {16'd0, mem_addr}, 32'h0000);
        check_val("rst2.len",    {30'd0, ins_len}, 32'd1);
        tick();
        reset = 1'b0; ins_ready = 1'b1;
        #1;
        check_val("rst2.first_addr", {16'd0, mem_addr}, 32'h0000);
        check_val("rst2.first_rd",   {31'd0, mem_rd}, 32'd1);
        repeat (2) tick();
        check_bundle("ldy2", 8'hA0, 16'h00FF, 2'd2, 16'h0000);

        for (int op = 0; op < 256; op++) begin
            dec_op = op[7:0];
            #1;
            check_val($sformatf("len_%02h", op), {30'd0, dec_len}, ref_len(op));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
